// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// RMW states exist only when LSU_BYTE_ACCESS_EN is defined.
package lsu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int RD_W_DEF   = 3;

    // Byte-lane select, taken from bit 0 of the byte address.
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2
`ifdef LSU_BYTE_ACCESS_EN
        ,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte extract / extend / merge for a 16-bit memory word.
// Only instantiated when LSU_BYTE_ACCESS_EN is defined.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] word,
    input  logic              lane,
    input  logic              sext,
    input  logic [7:0]        wbyte,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel  = (lane == LANE_HI) ? word[15:8] : word[7:0];
        load_data = {{(DATA_W-8){sext & byte_sel[7]}}, byte_sel};
        merged    = word;
        if (lane == LANE_HI) begin
            merged[15:8] = wbyte;
        end else begin
            merged[7:0]  = wbyte;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory request at a time between execute and data memory.
// Define LSU_BYTE_ACCESS_EN to add byte loads (zero/sign-extended) and read-modify-write byte stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = RD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_byte,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    state_t            state, state_next;
    logic              transfer;
    logic [RD_W-1:0]   rd_q;
    logic [ADDR_W-1:0] addr_map;
    logic [DATA_W-1:0] load_result;

`ifdef LSU_BYTE_ACCESS_EN
    logic              byte_q;
    logic              lane_q;
    logic              sext_q;
    logic [DATA_W-1:0] lane_load;
    logic [DATA_W-1:0] lane_merged;

    assign addr_map    = {1'b0, req_addr[ADDR_W-1:1]};
    assign load_result = byte_q ? lane_load : mem_rdata;

    // Store byte comes from mem_wdata[7:0], which holds req_wdata until RMW_RD closes.
    lsu_byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
        .word      (mem_rdata),
        .lane      (lane_q),
        .sext      (sext_q),
        .wbyte     (mem_wdata[7:0]),
        .load_data (lane_load),
        .merged    (lane_merged)
    );
`else
    logic unused_byte_cfg;

    assign unused_byte_cfg = req_byte ^ req_sext;
    assign addr_map        = req_addr;
    assign load_result     = mem_rdata;
`endif

    assign req_ready = rst_n && (state == IDLE);
    assign transfer  = req_valid && req_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    if (req_load) begin
                        state_next = LOAD;
                    end else begin
                        state_next = STORE;
`ifdef LSU_BYTE_ACCESS_EN
                        if (req_byte) state_next = RMW_RD;
`endif
                    end
                end
            end
            LOAD: begin
                mem_rd     = 1'b1;
                state_next = IDLE;
            end
            STORE: begin
                mem_wr     = 1'b1;
                state_next = IDLE;
            end
`ifdef LSU_BYTE_ACCESS_EN
            RMW_RD: begin
                mem_rd     = 1'b1;
                state_next = RMW_WR;
            end
            RMW_WR: begin
                mem_wr     = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
        // Reset aborts any in-flight access before it reaches memory.
        if (!rst_n) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_q      <= '0;
`ifdef LSU_BYTE_ACCESS_EN
            byte_q    <= 1'b0;
            lane_q    <= LANE_LO;
            sext_q    <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            wb_valid <= (state == LOAD);
            if (transfer) begin
                mem_addr <= addr_map;
                rd_q     <= req_rd;
                if (!req_load) mem_wdata <= req_wdata;
`ifdef LSU_BYTE_ACCESS_EN
                byte_q   <= req_byte;
                lane_q   <= req_addr[0];
                sext_q   <= req_sext;
`endif
            end
            if (state == LOAD) begin
                wb_rd   <= rd_q;
                wb_data <= load_result;
            end
`ifdef LSU_BYTE_ACCESS_EN
            if (state == RMW_RD) mem_wdata <= lane_merged;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural data memory.
// Byte-access steps are built only when LSU_BYTE_ACCESS_EN is defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load, req_byte, req_sext;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_rd;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        busy;

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .RD_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    assign mem_rdata = mem_rd ? mem[mem_addr] : 'z;
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   wb_count = 0;
    bit   started = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] widx(input logic [15:0] a);
`ifdef LSU_BYTE_ACCESS_EN
        return {1'b0, a[15:1]};
`else
        return a;
`endif
    endfunction

    function automatic bit byte_en(input logic by);
`ifdef LSU_BYTE_ACCESS_EN
        return by;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] ref_load(input logic [15:0] a, input logic by, input logic sx);
        logic [15:0] w;
        logic [7:0]  b;
        w = ref_mem[widx(a)];
        if (!byte_en(by)) return w;
        b = a[0] ? w[15:8] : w[7:0];
        return {{8{sx & b[7]}}, b};
    endfunction

    task automatic ref_store(input logic [15:0] a, input logic by, input logic [15:0] wd);
        logic [15:0] w;
        w = ref_mem[widx(a)];
        if (!byte_en(by))  w = wd;
        else if (a[0])     w[15:8] = wd[7:0];
        else               w[7:0]  = wd[7:0];
        ref_mem[widx(a)] = w;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (started) begin
            check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
            if (!rst_n) check("mem_forced_off_in_reset", {30'd0, mem_rd, mem_wr}, 32'd0);
            check("wb_data_known", {31'd0, $isunknown(wb_data)}, 32'd0);
            if (mem_wr) wr_count++;
            if (wb_valid) begin
                wb_count++;
                if (q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
                    check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
                    check("wb_latency", cyc, e.cyc);
                end
            end
        end
    end

    // Presents a request, waits (bounded) for acceptance, leaves req_valid high.
    task automatic issue(input logic ld, input logic by, input logic sx, input logic [15:0] a,
                         input logic [15:0] wd, input logic [2:0] rd, output int waited);
        exp_t x;
        req_load = ld; req_byte = by; req_sext = sx;
        req_addr = a;  req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("mem_addr", {16'd0, mem_addr}, {16'd0, widx(a)});
        check("mem_rd_first", {31'd0, mem_rd}, {31'd0, ld | byte_en(by)});
        check("mem_wr_first", {31'd0, mem_wr}, {31'd0, ~ld & ~byte_en(by)});
        if (ld) begin
            x.rd = rd; x.data = ref_load(a, by, sx); x.cyc = cyc + 1;
            q.push_back(x);
        end else begin
            if (!byte_en(by)) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, wd});
            ref_store(a, by, wd);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w0, p0;
        logic [15:0] orig, a;
        logic [15:0] st_addr [4] = '{16'h0000, 16'h7FFE, 16'h1234, 16'hFFFE};
        logic [15:0] st_data [4] = '{16'h0001, 16'h8000, 16'h5A5A, 16'hFFFF};

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'hA5C3;
            ref_mem[i] = 16'(i) ^ 16'hA5C3;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_byte = 1'b0; req_sext = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        started = 1;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Word store then load back.
        w0 = wr_count;
        issue(1'b0, 1'b0, 1'b0, 16'h0040, 16'hBEEF, 3'd0, w);
        idle(3);
        check("single_store_write", wr_count - w0, 32'd1);
        check("mem_after_store", {16'd0, mem[widx(16'h0040)]}, 32'h0000BEEF);
        issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 3'd5, w);
        idle(3);

        // Assorted word stores including the wrap-around corner.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, 1'b0, st_addr[i], st_data[i], 3'd0, w);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            check("mem_word_store", {16'd0, mem[widx(st_addr[i])]}, {16'd0, ref_mem[widx(st_addr[i])]});
        end

        // Back-to-back loads with req_valid held high.
        p0 = wb_count;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, 1'b0, st_addr[i], 16'h0000, 3'(i + 1), w);
            if (i > 0) check("b2b_wait_cycles", w, 32'd1);
        end
        idle(4);
        check("b2b_wb_pulses", wb_count - p0, 32'd4);

        // Reset during a word store aborts the write.
        orig = mem[widx(16'h0010)];
        w0 = wr_count;
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'hDEAD, 3'd0, w);
        rst_n = 1'b0;
        ref_mem[widx(16'h0010)] = orig;
        #1;
        check("mem_wr_off_in_reset", {31'd0, mem_wr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        check("aborted_store_mem", {16'd0, mem[widx(16'h0010)]}, {16'd0, orig});
        check("aborted_store_writes", wr_count - w0, 32'd0);
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        check("ready_after_abort", {31'd0, req_ready}, 32'd1);

        // Reset during a load suppresses its writeback strobe.
        p0 = wb_count;
        issue(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 3'd6, w);
        rst_n = 1'b0;
        void'(q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        check("aborted_load_no_wb", wb_count - p0, 32'd0);

        // Load at the top address followed by idle cycles with a floating bus.
        p0 = wb_count;
        issue(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 3'd7, w);
        idle(6);
        check("top_addr_wb_pulses", wb_count - p0, 32'd1);

`ifdef LSU_BYTE_ACCESS_EN
        a = 16'h0020;
        issue(1'b0, 1'b0, 1'b0, a, 16'h1280, 3'd0, w);
        idle(2);
        w0 = wr_count;
        issue(1'b0, 1'b1, 1'b0, 16'h0021, 16'h00AB, 3'd0, w);
        check("rmw_no_write_yet", {31'd0, mem_wr}, 32'd0);
        idle(4);
        check("rmw_single_write", wr_count - w0, 32'd1);
        check("byte_store_hi", {16'd0, mem[16'h0010]}, 32'h0000AB80);
        issue(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd2, w);
        issue(1'b1, 1'b1, 1'b0, 16'h0021, 16'h0000, 3'd3, w);
        issue(1'b1, 1'b1, 1'b1, 16'h0021, 16'h0000, 3'd4, w);
        idle(2);
        issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h007F, 3'd0, w);
        idle(4);
        check("byte_store_lo", {16'd0, mem[16'h0010]}, 32'h0000AB7F);
        issue(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0000, 3'd1, w);
        idle(3);
`else
        a = 16'h0000;
        issue(1'b1, 1'b1, 1'b1, a, 16'h0000, 3'd2, w);
        idle(3);
`endif

        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, address width; DATA_W, 16, data word width; RD_W, 3, destination-register index width.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  synchronous active-low reset
  req_valid  in  1  execute stage presents a memory request
  req_ready  out  1  unit accepts a request this cycle
  req_load  in  1  1 = load, 0 = store
  req_byte  in  1  byte access (used only when the macro is defined)
  req_sext  in  1  sign-extend byte load (used only when the macro is defined)
  req_addr  in  ADDR_W  effective address
  req_wdata  in  DATA_W  store data
  req_rd  in  RD_W  load destination register
  mem_rd  out  1  data-memory read enable
  mem_wr  out  1  data-memory write enable
  mem_addr  out  ADDR_W  data-memory word address
  mem_wdata  out  DATA_W  data-memory write data
  mem_rdata  in  DATA_W  data-memory combinational read data (high-Z when mem_rd=0)
  wb_valid  out  1  one-cycle load-result strobe to writeback
  wb_rd  out  RD_W  load destination register
  wb_data  out  DATA_W  load result
  busy  out  1  state != IDLE (pipeline stall)
REQ-003 The unit SHALL have one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, STORE, RMW_RD, RMW_WR; RMW_* exist only with the macro defined.
REQ-005 req_ready SHALL be 1 exactly when state==IDLE and rst_n==1; a transfer occurs on a rising edge with req_valid&&req_ready.
REQ-006 On transfer the unit SHALL latch addr, wdata, rd, load, byte, sext and go to LOAD (load), STORE (word store) or RMW_RD (byte store).
REQ-007 LOAD: mem_rd=1 for exactly one cycle; mem_rdata is sampled at that cycle's closing edge into wb_data; next state IDLE with wb_valid=1 for exactly one cycle.
REQ-008 Load latency SHALL be: accept at edge N, wb_valid high during cycle N+1..N+2 (one cycle, after edge N+1); one request per 2 cycles sustained for loads and word stores.
REQ-009 STORE: mem_wr=1, mem_wdata=latched data for exactly one cycle, then IDLE; no wb_valid.
REQ-010 mem_rd and mem_wr SHALL never both be 1; both are 0 in IDLE; both are forced 0 combinationally while rst_n==0.
REQ-011 mem_rdata SHALL be sampled only in states with mem_rd=1; a high-Z value never enters wb_data.
REQ-012 mem_addr and mem_wdata SHALL hold their last values outside access states; wb_data and wb_rd SHALL hold until the next load completes.
REQ-013 A new request accepted in the same IDLE cycle that wb_valid is high SHALL be legal and SHALL NOT disturb that strobe.
REQ-014 Word access: mem_addr = req_addr, full wrap-around at 16'hFFFF, no alignment check.

Reset
REQ-015 With rst_n==0 at a rising edge: state=IDLE, wb_valid=0, wb_rd=0, wb_data=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-016 Reset during any non-IDLE state SHALL abort the request: no memory write during or after the reset cycle, no wb_valid.

Configuration
REQ-017 Macro LSU_BYTE_ACCESS_EN SHALL enable byte access; without it req_byte and req_sext are ignored and every access is word-sized.
REQ-018 With the macro: mem_addr = {1'b0, req_addr[15:1]}; req_addr[0]=0 selects bits [7:0], 1 selects [15:8].
REQ-019 Byte load: selected byte zero-extended, or sign-extended when sext=1; same latency as a word load.
REQ-020 Byte store: RMW_RD (mem_rd=1, capture the word) then RMW_WR (mem_wr=1, merged word), then IDLE; 3 cycles from acceptance.

Structure
REQ-021 Package lsu_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W/RD_W defaults, and the byte-lane select constants.
REQ-022 Sub-module lsu_byte_lane (combinational byte extract/extend/merge) SHALL be instantiated only with LSU_BYTE_ACCESS_EN.

Verification
REQ-023 Word store addr 16'h0040 data 16'hBEEF, then load 16'h0040 rd=5 -> exactly one mem_wr cycle, then wb_valid one cycle with wb_rd=5 and wb_data=16'hBEEF.
REQ-024 Back-to-back: req_valid held high with 4 loads -> req_ready alternates 1/0, 4 wb_valid pulses, mem_rd and mem_wr never both high.
REQ-025 rst_n low during the STORE cycle to addr 16'h0010 -> the memory word is unchanged, busy=0 and req_ready=1 after release.
REQ-026 Byte build: word 16'h1280, byte store 16'h00AB at byte address 16'h0021 -> word at 16'h0010 = 16'hAB80; sext byte load at 16'h0020 -> 16'hFF80.
REQ-027 Load at addr 16'hFFFF, plus idle cycles with mem_rdata driven 'z -> wb_data never X or Z, and wb_valid stays 0 in the idle cycles.
